servant_wb_arbiter: RTL and testbench
=====================================

Name: servant_wb_arbiter

Overview:
- Two-master Wishbone arbiter that shares the single CPU-side port of the servant address-decode mux between master 0 (SERV CPU) and master 1 (DMA/accelerator loader).
- Round-robin grant, locked for one whole transaction; owns a bus-timeout watchdog so an unacked access cannot hang either master.
- Sits directly upstream of the mux; the mux and its slaves see exactly one master.

Parameters:
- TIMEOUT, 64, cycles in a granted state without slave ack before error termination (must be >= 2).
- ERR_RDT, 32'hDEAD_BEEF, read data returned to the master on a timeout termination.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wb_m0_adr / i_wb_m1_adr  in  32  master address
- i_wb_m0_dat / i_wb_m1_dat  in  32  master write data
- i_wb_m0_sel / i_wb_m1_sel  in  4  byte selects
- i_wb_m0_we / i_wb_m1_we  in  1  write enable
- i_wb_m0_cyc / i_wb_m1_cyc  in  1  cycle request
- o_wb_m0_rdt / o_wb_m1_rdt  out  32  read data
- o_wb_m0_ack / o_wb_m1_ack  out  1  transaction acknowledge
- o_wb_s_adr  out  32  to mux address
- o_wb_s_dat  out  32  to mux write data
- o_wb_s_sel  out  4  to mux byte selects
- o_wb_s_we  out  1  to mux write enable
- o_wb_s_cyc  out  1  to mux cycle
- i_wb_s_rdt  in  32  from mux read data
- i_wb_s_ack  in  1  from mux acknowledge (registered in the mux)
- o_grant  out  2  one-hot current owner, 00 when idle
- o_err  out  1  one-cycle pulse on timeout termination

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, last-owner=1 (m0 wins first tie), watchdog=0, all acks/o_err/o_wb_s_cyc=0, o_grant=00.
- States: IDLE, BUSY0, BUSY1.
- IDLE transitions:
  - only m0 cyc -> BUSY0; only m1 cyc -> BUSY1.
  - both cyc -> the master not equal to last-owner; last-owner updates on entry.
  - none -> stay.
  - Grant latency: 1 cycle from cyc seen to o_wb_s_cyc.
- Outputs in IDLE: o_wb_s_cyc=0, remaining slave outputs driven from m0 (don't-care). The forced idle cycle between transactions is required: the mux ack is cyc&!ack registered and must see cyc low.
- BUSYn outputs:
  - Slave adr/dat/sel/we = master n's inputs.
  - o_wb_s_cyc = i_wb_mn_cyc.
  - o_wb_mn_ack = i_wb_s_ack (combinational pass-through); o_wb_mn_rdt = i_wb_s_rdt.
  - The non-owner's ack is 0 and its rdt is don't-care (driven with i_wb_s_rdt).
- BUSYn exits:
  - i_wb_s_ack -> IDLE next cycle.
  - Master n drops cyc before ack -> IDLE next cycle, no ack issued, no error.
  - Watchdog reaches TIMEOUT-1 without ack -> that cycle o_wb_mn_ack=1, o_wb_mn_rdt=ERR_RDT, o_err=1, o_wb_s_cyc forced 0; -> IDLE.
  - Ack and timeout in the same cycle: ack wins, normal data, no o_err.
- Watchdog: clears in IDLE, increments each BUSY cycle, width $clog2(TIMEOUT)+1, never wraps.
- Requests held by the non-owner are simply stalled (no ack); they are served at the next IDLE.
- Reset mid-transaction: immediate return to IDLE, and all outputs go to reset values asynchronously.

Decomposition:
- Package servant_arb_pkg: state encoding (IDLE=2'd0, BUSY0=2'd1, BUSY1=2'd2) and default ERR_RDT constant.
- One natural sub-module: servant_arb_watchdog (clear, enable, TIMEOUT parameter, expire output).

Test Plan:
- m0 read adr 0x0000_0010, s_ack 2 cycles after cyc, s_rdt 0x1234_5678 -> m0 ack 1 cycle, m0 rdt 0x1234_5678, o_grant 01, m1 ack never.
- m0 and m1 hold cyc continuously, 4 transactions -> grants m0,m1,m0,m1, with s_cyc low exactly one cycle between each.
- m1 write adr 0x4000_0000 dat 0x1 sel 0xF while m0 idle -> slave sees m1 adr/dat/we=1, m1 acked, o_grant 10.
- TIMEOUT=8, slave never acks m0 -> on BUSY cycle 8: m0 ack=1, rdt=0xDEAD_BEEF, o_err pulse 1 cycle, s_cyc drops.
- Assert i_rst_n=0 mid BUSY1 -> same-cycle s_cyc=0, o_grant=00; after release, simultaneous requests grant m0 first.
- m0 drops cyc in BUSY0 before ack -> IDLE next cycle, no ack, o_err=0.

Source files
------------

// File: rtl/servant_arb_pkg.sv
// Shared definitions for the servant two-master Wishbone arbiter.
package servant_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arbState_t;

    // Read data handed back to a master whose access was killed by the watchdog
    localparam logic [31:0] DEFAULT_ERR_RDT = 32'hDEAD_BEEF;

endpackage

// File: rtl/servant_arb_watchdog.sv
// Bus-timeout watchdog: counts granted cycles and flags expiry at TIMEOUT-1.
module servant_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int               CW    = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]    LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Count busy cycles, saturating at the limit so the counter can never wrap
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/servant_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the servant address mux.
// Grant is held for a whole transaction; a watchdog terminates hung accesses.
module servant_wb_arbiter
    import servant_arb_pkg::*;
#(
    parameter int          TIMEOUT = 64,
    parameter logic [31:0] ERR_RDT = DEFAULT_ERR_RDT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_wb_m0_adr,
    input  logic [31:0] i_wb_m0_dat,
    input  logic [3:0]  i_wb_m0_sel,
    input  logic        i_wb_m0_we,
    input  logic        i_wb_m0_cyc,
    output logic [31:0] o_wb_m0_rdt,
    output logic        o_wb_m0_ack,
    input  logic [31:0] i_wb_m1_adr,
    input  logic [31:0] i_wb_m1_dat,
    input  logic [3:0]  i_wb_m1_sel,
    input  logic        i_wb_m1_we,
    input  logic        i_wb_m1_cyc,
    output logic [31:0] o_wb_m1_rdt,
    output logic        o_wb_m1_ack,
    output logic [31:0] o_wb_s_adr,
    output logic [31:0] o_wb_s_dat,
    output logic [3:0]  o_wb_s_sel,
    output logic        o_wb_s_we,
    output logic        o_wb_s_cyc,
    input  logic [31:0] i_wb_s_rdt,
    input  logic        i_wb_s_ack,
    output logic [1:0]  o_grant,
    output logic        o_err
);

    arbState_t r_state;
    logic      r_lastOwner;
    logic      w_busy;
    logic      w_expire;
    logic      w_ownerCyc;
    logic      w_timeout;

    assign w_busy     = (r_state != IDLE);
    assign w_ownerCyc = (r_state == BUSY1) ? i_wb_m1_cyc : i_wb_m0_cyc;
    // A slave ack in the expiry cycle wins; a master that already let go gets no error ack
    assign w_timeout  = w_busy && w_expire && !i_wb_s_ack && w_ownerCyc;

    servant_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (!w_busy),
        .i_enable (w_busy),
        .o_expire (w_expire)
    );

    // Grant FSM: pick an owner from IDLE, hold it until ack, drop of cyc or timeout
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_lastOwner <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_wb_m0_cyc && i_wb_m1_cyc) begin
                        if (r_lastOwner) begin
                            r_state     <= BUSY0;
                            r_lastOwner <= 1'b0;
                        end else begin
                            r_state     <= BUSY1;
                            r_lastOwner <= 1'b1;
                        end
                    end else if (i_wb_m0_cyc) begin
                        r_state     <= BUSY0;
                        r_lastOwner <= 1'b0;
                    end else if (i_wb_m1_cyc) begin
                        r_state     <= BUSY1;
                        r_lastOwner <= 1'b1;
                    end
                end
                BUSY0: begin
                    if (i_wb_s_ack || !i_wb_m0_cyc || w_expire) begin
                        r_state <= IDLE;
                    end
                end
                BUSY1: begin
                    if (i_wb_s_ack || !i_wb_m1_cyc || w_expire) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Route the owner onto the slave port and return ack/data only to the owner
    always_comb begin
        o_wb_s_adr  = i_wb_m0_adr;
        o_wb_s_dat  = i_wb_m0_dat;
        o_wb_s_sel  = i_wb_m0_sel;
        o_wb_s_we   = i_wb_m0_we;
        o_wb_s_cyc  = 1'b0;
        o_wb_m0_ack = 1'b0;
        o_wb_m1_ack = 1'b0;
        o_wb_m0_rdt = i_wb_s_rdt;
        o_wb_m1_rdt = i_wb_s_rdt;
        o_err       = 1'b0;
        o_grant     = 2'b00;
        case (r_state)
            BUSY0: begin
                o_wb_s_cyc  = i_wb_m0_cyc && !w_timeout;
                o_wb_m0_ack = i_wb_s_ack || w_timeout;
                o_wb_m0_rdt = w_timeout ? ERR_RDT : i_wb_s_rdt;
                o_err       = w_timeout;
                o_grant     = 2'b01;
            end
            BUSY1: begin
                o_wb_s_adr  = i_wb_m1_adr;
                o_wb_s_dat  = i_wb_m1_dat;
                o_wb_s_sel  = i_wb_m1_sel;
                o_wb_s_we   = i_wb_m1_we;
                o_wb_s_cyc  = i_wb_m1_cyc && !w_timeout;
                o_wb_m1_ack = i_wb_s_ack || w_timeout;
                o_wb_m1_rdt = w_timeout ? ERR_RDT : i_wb_s_rdt;
                o_err       = w_timeout;
                o_grant     = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_servant_wb_arbiter.sv
// Self-checking bench for servant_wb_arbiter with a transaction-level model.
module tb_servant_wb_arbiter;

    localparam int          TIMEOUT = 8;
    localparam logic [31:0] ERR_RDT = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0Adr, m0Dat, m1Adr, m1Dat, sRdt;
    logic [3:0]  m0Sel, m1Sel;
    logic        m0We, m1We, m0Cyc, m1Cyc;
    logic [31:0] m0Rdt, m1Rdt, sAdr, sDat;
    logic [3:0]  sSel;
    logic        m0Ack, m1Ack, sWe, sCyc, sAck, err;
    logic [1:0]  grant;

    logic [31:0] nxtM0Adr, nxtM0Dat, nxtM1Adr, nxtM1Dat, nxtSRdt;
    logic [3:0]  nxtM0Sel, nxtM1Sel;
    logic        nxtM0We, nxtM1We;
    logic        muxEn, muxAck;

    int checks = 0;
    int passed = 0;

    int owner     = -1;
    int busyCycle = 0;
    int lastOwner = 1;

    int grantLog[$];
    int gapLog[$];

    servant_wb_arbiter #(
        .TIMEOUT (TIMEOUT),
        .ERR_RDT (ERR_RDT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wb_m0_adr (m0Adr),
        .i_wb_m0_dat (m0Dat),
        .i_wb_m0_sel (m0Sel),
        .i_wb_m0_we  (m0We),
        .i_wb_m0_cyc (m0Cyc),
        .o_wb_m0_rdt (m0Rdt),
        .o_wb_m0_ack (m0Ack),
        .i_wb_m1_adr (m1Adr),
        .i_wb_m1_dat (m1Dat),
        .i_wb_m1_sel (m1Sel),
        .i_wb_m1_we  (m1We),
        .i_wb_m1_cyc (m1Cyc),
        .o_wb_m1_rdt (m1Rdt),
        .o_wb_m1_ack (m1Ack),
        .o_wb_s_adr  (sAdr),
        .o_wb_s_dat  (sDat),
        .o_wb_s_sel  (sSel),
        .o_wb_s_we   (sWe),
        .o_wb_s_cyc  (sCyc),
        .i_wb_s_rdt  (sRdt),
        .i_wb_s_ack  (sAck),
        .o_grant     (grant),
        .o_err       (err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Stand-in for the address mux: ack is cyc & !ack registered
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) muxAck <= 1'b0;
        else        muxAck <= muxEn & sCyc & ~muxAck;
    end
    assign sAck = muxAck;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Advance one cycle and drive the next vector shortly after the clock edge
    task automatic applyStimulus(input logic c0, input logic c1, input logic en);
        @(posedge clk);
        #2;
        m0Cyc = c0;       m1Cyc = c1;       muxEn = en;
        m0Adr = nxtM0Adr; m0Dat = nxtM0Dat; m0Sel = nxtM0Sel; m0We = nxtM0We;
        m1Adr = nxtM1Adr; m1Dat = nxtM1Dat; m1Sel = nxtM1Sel; m1We = nxtM1We;
        sRdt  = nxtSRdt;
    endtask

    // Expected outputs from the arbitration rules: who owns the bus, how long it has waited
    task automatic checkOutput();
        int   own;
        logic ownCyc;
        logic tmo;
        own    = rst_n ? owner : -1;
        ownCyc = (own == 1) ? m1Cyc : ((own == 0) ? m0Cyc : 1'b0);
        tmo    = (own >= 0) && (busyCycle == TIMEOUT) && !sAck && ownCyc;
        cmp("grant",  {30'b0, grant}, (own < 0) ? 0 : ((own == 0) ? 1 : 2));
        cmp("s_cyc",  sCyc,  (own >= 0) && ownCyc && !tmo);
        cmp("s_adr",  sAdr,  (own == 1) ? m1Adr : m0Adr);
        cmp("s_dat",  sDat,  (own == 1) ? m1Dat : m0Dat);
        cmp("s_sel",  sSel,  (own == 1) ? m1Sel : m0Sel);
        cmp("s_we",   sWe,   (own == 1) ? m1We : m0We);
        cmp("m0_ack", m0Ack, (own == 0) && (sAck || tmo));
        cmp("m1_ack", m1Ack, (own == 1) && (sAck || tmo));
        cmp("m0_rdt", m0Rdt, ((own == 0) && tmo) ? ERR_RDT : sRdt);
        cmp("m1_rdt", m1Rdt, ((own == 1) && tmo) ? ERR_RDT : sRdt);
        cmp("err",    err,   tmo);
    endtask

    // Advance the model to what the coming clock edge will produce
    task automatic modelStep();
        logic ownCyc;
        if (!rst_n) begin
            owner     = -1;
            busyCycle = 0;
            lastOwner = 1;
        end else if (owner < 0) begin
            if (m0Cyc && m1Cyc) owner = 1 - lastOwner;
            else if (m0Cyc)     owner = 0;
            else if (m1Cyc)     owner = 1;
            if (owner >= 0) begin
                lastOwner = owner;
                busyCycle = 1;
            end
        end else begin
            ownCyc = (owner == 0) ? m0Cyc : m1Cyc;
            if (sAck || !ownCyc || busyCycle == TIMEOUT) owner = -1;
            else busyCycle++;
        end
    endtask

    // Compare every cycle on the falling edge, then step the model
    initial begin
        forever begin
            @(negedge clk);
            checkOutput();
            modelStep();
        end
    end

    // Hard stop in case the stimulus never completes
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int expGrant[4];
        logic gapCounting;
        int gap;
        expGrant = '{1, 2, 1, 2};
        rst_n = 1'b0;
        m0Cyc = 0; m1Cyc = 0; muxEn = 0;
        m0Adr = 0; m0Dat = 0; m0Sel = 0; m0We = 0;
        m1Adr = 0; m1Dat = 0; m1Sel = 0; m1We = 0; sRdt = 0;
        nxtM0Adr = 0; nxtM0Dat = 0; nxtM0Sel = 4'hF; nxtM0We = 0;
        nxtM1Adr = 0; nxtM1Dat = 0; nxtM1Sel = 4'hF; nxtM1We = 0;
        nxtSRdt  = 32'h0;

        // Reset state
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        cmp("rst_grant", {30'b0, grant}, 0);
        cmp("rst_s_cyc", sCyc, 0);
        cmp("rst_acks",  {m0Ack, m1Ack}, 0);
        cmp("rst_err",   err, 0);
        applyStimulus(0, 0, 0);
        rst_n = 1'b1;

        // Both masters hold cyc: alternating grants with a one-cycle gap
        $display("[TB] both masters contend");
        nxtM0Adr = 32'h0000_0100; nxtM0We = 0;
        nxtM1Adr = 32'h0000_0200; nxtM1We = 1; nxtM1Dat = 32'hA5A5_5A5A;
        nxtSRdt  = 32'h0BAD_F00D;
        gapCounting = 0;
        gap = 0;
        for (int k = 0; k < 13; k++) begin
            applyStimulus(1, 1, 1);
            @(negedge clk);
            if (m0Ack || m1Ack) begin
                grantLog.push_back(int'(grant));
                gapCounting = 1;
                gap = 0;
            end else if (gapCounting) begin
                if (!sCyc) gap++;
                else begin
                    gapLog.push_back(gap);
                    gapCounting = 0;
                end
            end
        end
        cmp("rr_ack_count", grantLog.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < grantLog.size()) cmp("rr_grant_order", grantLog[i], expGrant[i]);
        cmp("rr_gap_count", gapLog.size(), 3);
        for (int i = 0; i < gapLog.size(); i++) cmp("rr_idle_gap", gapLog[i], 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);

        // m0 read with slave ack two cycles after cyc
        $display("[TB] m0 read");
        nxtM0Adr = 32'h0000_0010; nxtM0We = 0; nxtSRdt = 32'h1234_5678;
        applyStimulus(1, 0, 1);
        applyStimulus(1, 0, 1);
        @(negedge clk);
        cmp("t1_grant", {30'b0, grant}, 1);
        cmp("t1_s_cyc", sCyc, 1);
        cmp("t1_s_adr", sAdr, 32'h0000_0010);
        applyStimulus(1, 0, 1);
        @(negedge clk);
        cmp("t1_m0_ack", m0Ack, 1);
        cmp("t1_m0_rdt", m0Rdt, 32'h1234_5678);
        cmp("t1_m1_ack", m1Ack, 0);
        applyStimulus(0, 0, 1);
        @(negedge clk);
        cmp("t1_idle_grant", {30'b0, grant}, 0);
        cmp("t1_ack_done",   m0Ack, 0);

        // m1 write while m0 idle
        $display("[TB] m1 write");
        nxtM0Adr = 32'h0; nxtM1Adr = 32'h4000_0000; nxtM1Dat = 32'h1;
        nxtM1Sel = 4'hF;  nxtM1We = 1;
        applyStimulus(0, 1, 1);
        applyStimulus(0, 1, 1);
        @(negedge clk);
        cmp("t3_s_adr", sAdr, 32'h4000_0000);
        cmp("t3_s_dat", sDat, 32'h1);
        cmp("t3_s_we",  sWe,  1);
        cmp("t3_s_sel", sSel, 4'hF);
        cmp("t3_grant", {30'b0, grant}, 2);
        applyStimulus(0, 1, 1);
        @(negedge clk);
        cmp("t3_m1_ack", m1Ack, 1);
        cmp("t3_m0_ack", m0Ack, 0);
        applyStimulus(0, 0, 1);

        // Slave never acks m0: watchdog terminates on busy cycle 8
        $display("[TB] watchdog timeout");
        nxtM0Adr = 32'h0000_0020; nxtM0We = 0; nxtSRdt = 32'h5555_AAAA;
        applyStimulus(1, 0, 0);
        for (int i = 1; i <= 7; i++) applyStimulus(1, 0, 0);
        @(negedge clk);
        cmp("t4_pre_err",   err,  0);
        cmp("t4_pre_s_cyc", sCyc, 1);
        cmp("t4_pre_ack",   m0Ack, 0);
        applyStimulus(1, 0, 0);
        @(negedge clk);
        cmp("t4_ack",   m0Ack, 1);
        cmp("t4_rdt",   m0Rdt, 32'hDEAD_BEEF);
        cmp("t4_err",   err,   1);
        cmp("t4_s_cyc", sCyc,  0);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        cmp("t4_err_pulse", err, 0);
        cmp("t4_grant",     {30'b0, grant}, 0);

        // m0 abandons its cycle before any ack
        $display("[TB] m0 drops cyc");
        nxtM0Adr = 32'h0000_0030;
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        @(negedge clk);
        cmp("t6_grant", {30'b0, grant}, 1);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        cmp("t6_s_cyc", sCyc, 0);
        cmp("t6_ack",   m0Ack, 0);
        cmp("t6_err",   err, 0);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        cmp("t6_idle", {30'b0, grant}, 0);
        cmp("t6_err2", err, 0);

        // Reset asserted in the middle of an m1 transaction
        $display("[TB] reset during BUSY1");
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        @(negedge clk);
        cmp("t5_grant_busy", {30'b0, grant}, 2);
        applyStimulus(0, 1, 0);
        #1 rst_n = 1'b0;
        #1;
        cmp("t5_async_s_cyc", sCyc, 0);
        cmp("t5_async_grant", {30'b0, grant}, 0);
        cmp("t5_async_ack",   m1Ack, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 1, 1);
        rst_n = 1'b1;
        applyStimulus(1, 1, 1);
        @(negedge clk);
        cmp("t5_first_grant", {30'b0, grant}, 1);
        applyStimulus(1, 1, 1);
        applyStimulus(1, 1, 1);
        applyStimulus(1, 1, 1);
        @(negedge clk);
        cmp("t5_second_grant", {30'b0, grant}, 2);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
